// File: rtl/pingpong_read_ctrl_if.sv
// Read-side bus of the ping-pong read controller: RAM read port plus the
// valid/ready sample stream toward the FFT.
// master: the controller; slave: the RAM + stream consumer side.
interface pingpong_read_ctrl_if #(
  parameter int WIDTH = 24,
  parameter int AW    = 8
);
  logic             rd_en_o;
  logic [AW-1:0]    rd_addr_o;
  logic             rd_buf_sel_o;
  logic [WIDTH-1:0] rd_data_i;
  logic [WIDTH-1:0] m_data_o;
  logic             m_valid_o;
  logic             m_ready_i;
  logic             m_last_o;

  modport master (
    output rd_en_o, rd_addr_o, rd_buf_sel_o,
    input  rd_data_i,
    output m_data_o, m_valid_o, m_last_o,
    input  m_ready_i
  );

  modport slave (
    input  rd_en_o, rd_addr_o, rd_buf_sel_o,
    output rd_data_i,
    input  m_data_o, m_valid_o, m_last_o,
    output m_ready_i
  );
endinterface

// File: rtl/pingpong_read_ctrl.sv
// Ping-pong buffer read controller: after a buffer_ready pulse, reads
// DEPTH samples from the filled buffer (1-cycle RAM latency) through a
// 2-entry skid FIFO onto a valid/ready stream with a last marker.
// Optional feature macro: RDCTRL_RESTART_EN -- an overrun pulse aborts the
// current block and restarts on the newly announced buffer. Without it the
// overrun pulse only sets the sticky flag.
module pingpong_read_ctrl #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        buffer_ready_i,
  input  logic        buf_sel_i,
  pingpong_read_ctrl_if.master bus,
  output logic        busy_o,
  output logic        overrun_o,
  input  logic        overrun_clr_i,
  output logic [15:0] block_cnt_o
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t           state_q, state_d;
  logic [AW-1:0]    rd_addr_q;
  logic             rd_buf_sel_q;
  logic             infl_q;        // a RAM read issued last cycle
  logic             infl_last_q;   // that read was address DEPTH-1
  logic [1:0]       fifo_cnt_q;
  logic             wr_ptr_q, rd_ptr_q;
  logic [WIDTH-1:0] fifo_data [2];
  logic             fifo_last [2];
  logic             ovr_q;
  logic [15:0]      blk_cnt_q;

  logic       rd_en, start, ovr_set, restart, done;
  logic       fifo_wr, pop, head_last, last_xfer;
  logic [1:0] pending;

  assign pending   = fifo_cnt_q + {1'b0, infl_q};
  assign head_last = fifo_last[rd_ptr_q];
  assign pop       = (fifo_cnt_q != 2'd0) && bus.m_ready_i;
  assign last_xfer = pop && head_last;
  assign fifo_wr   = infl_q && !restart;

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next state, read issue and block start/finish/overrun decisions
  always_comb begin
    state_d = state_q;
    rd_en   = 1'b0;
    start   = 1'b0;
    ovr_set = 1'b0;
    restart = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (buffer_ready_i) begin
          start   = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (pending < 2'd2) begin
          rd_en = 1'b1;
          if (rd_addr_q == AW'(DEPTH - 1)) state_d = DRAIN;
        end
        if (buffer_ready_i) ovr_set = 1'b1;
      end
      DRAIN: begin
        if (last_xfer) begin
          done = 1'b1;
          // A new buffer announced on the last handshake is a clean start.
          if (buffer_ready_i) begin
            start   = 1'b1;
            state_d = RUN;
          end else begin
            state_d = IDLE;
          end
        end else if (buffer_ready_i) begin
          ovr_set = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
`ifdef RDCTRL_RESTART_EN
    if (ovr_set) begin
      restart = 1'b1;
      start   = 1'b1;
      state_d = RUN;
    end
`else
    restart = 1'b0;
`endif
  end

  // Read address/buffer select, in-flight tracking, FIFO pointers, flags
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_addr_q    <= '0;
      rd_buf_sel_q <= 1'b0;
      infl_q       <= 1'b0;
      infl_last_q  <= 1'b0;
      fifo_cnt_q   <= 2'd0;
      wr_ptr_q     <= 1'b0;
      rd_ptr_q     <= 1'b0;
      ovr_q        <= 1'b0;
      blk_cnt_q    <= 16'd0;
    end else begin
      if (start) begin
        rd_addr_q    <= '0;
        rd_buf_sel_q <= buf_sel_i;
      end else if (rd_en) begin
        rd_addr_q    <= rd_addr_q + AW'(1);
      end
      // A restart discards the read issued in the same cycle.
      infl_q      <= rd_en && !restart;
      infl_last_q <= rd_en && (rd_addr_q == AW'(DEPTH - 1));
      if (restart) begin
        fifo_cnt_q <= 2'd0;
        wr_ptr_q   <= 1'b0;
        rd_ptr_q   <= 1'b0;
      end else begin
        if (fifo_wr) wr_ptr_q <= ~wr_ptr_q;
        if (pop)     rd_ptr_q <= ~rd_ptr_q;
        case ({fifo_wr, pop})
          2'b10:   fifo_cnt_q <= fifo_cnt_q + 2'd1;
          2'b01:   fifo_cnt_q <= fifo_cnt_q - 2'd1;
          default: fifo_cnt_q <= fifo_cnt_q;
        endcase
      end
      if (ovr_set)            ovr_q <= 1'b1;
      else if (overrun_clr_i) ovr_q <= 1'b0;
      if (done) blk_cnt_q <= blk_cnt_q + 16'd1;
    end
  end

  // FIFO storage: data path only, qualified by the occupancy count
  always_ff @(posedge clk_i) begin
    if (fifo_wr) begin
      fifo_data[wr_ptr_q] <= bus.rd_data_i;
      fifo_last[wr_ptr_q] <= infl_last_q;
    end
  end

  assign bus.rd_en_o      = rd_en;
  assign bus.rd_addr_o    = rd_addr_q;
  assign bus.rd_buf_sel_o = rd_buf_sel_q;
  assign bus.m_valid_o    = (fifo_cnt_q != 2'd0);
  assign bus.m_data_o     = bus.m_valid_o ? fifo_data[rd_ptr_q] : '0;
  assign bus.m_last_o     = bus.m_valid_o && head_last;
  assign busy_o           = (state_q != IDLE);
  assign overrun_o        = ovr_q;
  assign block_cnt_o      = blk_cnt_q;

endmodule

// File: tb/tb_pingpong_read_ctrl.sv
// Directed bench for pingpong_read_ctrl with DEPTH=8. A RAM model returns
// {buf_sel, addr} one cycle after each read strobe, so every stream beat
// identifies its own buffer and address.
module tb_pingpong_read_ctrl;
  localparam int WIDTH = 24;
  localparam int DEPTH = 8;
  localparam int AW    = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        buffer_ready, buf_sel, ovr_clr;
  logic        busy, overrun;
  logic [15:0] block_cnt;

  pingpong_read_ctrl_if #(.WIDTH(WIDTH), .AW(AW)) bus ();

  pingpong_read_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .buffer_ready_i (buffer_ready),
    .buf_sel_i      (buf_sel),
    .bus            (bus),
    .busy_o         (busy),
    .overrun_o      (overrun),
    .overrun_clr_i  (ovr_clr),
    .block_cnt_o    (block_cnt)
  );

  always #5 clk = ~clk;

  // RAM model: contents = {buffer, address}
  always_ff @(posedge clk) begin
    if (bus.rd_en_o) bus.rd_data_i <= {15'd0, bus.rd_buf_sel_o, bus.rd_addr_o};
  end

  int checks = 0;
  int errors = 0;

  logic [23:0] bdata[$];
  logic        blast[$];
  int          beats, issued, maxout, cyc_n, first_valid, stall_err;
  logic        prev_stall;
  logic [23:0] prev_data;
  logic        prev_last;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_logs();
    bdata.delete();
    blast.delete();
    beats = 0; issued = 0; maxout = 0; first_valid = -1; stall_err = 0;
    prev_stall = 1'b0; prev_data = '0; prev_last = 1'b0;
  endtask

  // One clock: drive inputs after the falling edge, then sample what the
  // coming rising edge will see.
  task automatic cyc(input logic rdy, input logic br, input logic sel, input logic clr);
    @(negedge clk);
    bus.m_ready_i = rdy; buffer_ready = br; buf_sel = sel; ovr_clr = clr;
    #1;
    cyc_n++;
    if (prev_stall && (!bus.m_valid_o || bus.m_data_o !== prev_data || bus.m_last_o !== prev_last))
      stall_err++;
    prev_stall = bus.m_valid_o && !rdy;
    prev_data  = bus.m_data_o;
    prev_last  = bus.m_last_o;
    if (bus.m_valid_o && first_valid < 0) first_valid = cyc_n;
    if (bus.rd_en_o) issued++;
    if (bus.m_valid_o && rdy) begin
      bdata.push_back(bus.m_data_o);
      blast.push_back(bus.m_last_o);
      beats++;
    end
    if (issued - beats > maxout) maxout = issued - beats;
  endtask

  // mode 0: ready always high; mode 1: ready pattern 1,0,0,1,...
  task automatic run_idle(input int mode, input int maxc, input string tag);
    bit fin = 1'b0;
    logic r;
    for (int i = 0; i < maxc; i++) begin
      r = (mode == 0) ? 1'b1 : ((i % 4 == 0) || (i % 4 == 3));
      cyc(r, 1'b0, 1'b0, 1'b0);
      if (!busy) begin fin = 1'b1; break; end
    end
    chk({tag, "_done"}, 32'(fin), 32'd1);
  endtask

  task automatic chk_block(input string tag, input int first, input int n, input logic b);
    logic [31:0] lm = '0;
    if (bdata.size() >= first + n) begin
      for (int k = 0; k < n; k++) begin
        chk($sformatf("%s_d%0d", tag, k), 32'(bdata[first + k]), {8'd0, 15'd0, b, 8'(k)});
        if (blast[first + k]) lm |= (32'd1 << k);
      end
      chk({tag, "_lastmask"}, lm, 32'd1 << (n - 1));
    end else begin
      chk({tag, "_enough_beats"}, 32'(bdata.size()), 32'(first + n));
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_rd_en"},   32'(bus.rd_en_o), 0);
    chk({tag, "_rd_addr"}, 32'(bus.rd_addr_o), 0);
    chk({tag, "_rd_sel"},  32'(bus.rd_buf_sel_o), 0);
    chk({tag, "_valid"},   32'(bus.m_valid_o), 0);
    chk({tag, "_last"},    32'(bus.m_last_o), 0);
    chk({tag, "_data"},    32'(bus.m_data_o), 0);
    chk({tag, "_busy"},    32'(busy), 0);
    chk({tag, "_overrun"}, 32'(overrun), 0);
    chk({tag, "_blkcnt"},  32'(block_cnt), 0);
  endtask

  initial begin
    int p, n;
    logic r;
    rst_n = 1'b0; buffer_ready = 1'b0; buf_sel = 1'b0; ovr_clr = 1'b0;
    bus.m_ready_i = 1'b0;
    cyc_n = 0;
    clear_logs();
    repeat (3) @(posedge clk);
    #1;
    chk_reset("rst");
    @(negedge clk);
    rst_n = 1'b1;

    // Single block from buffer 1, ready always high
    clear_logs();
    cyc(1'b1, 1'b1, 1'b1, 1'b0);
    p = cyc_n;
    run_idle(0, 60, "A");
    chk("A_latency", 32'(first_valid - p), 32'd3);
    chk("A_beats", 32'(beats), 32'd8);
    chk_block("A", 0, 8, 1'b1);
    chk("A_blkcnt", 32'(block_cnt), 32'd1);
    chk("A_busy", 32'(busy), 32'd0);
    chk("A_overrun", 32'(overrun), 32'd0);
    chk("A_rd_sel", 32'(bus.rd_buf_sel_o), 32'd1);
    chk("A_rd_addr_hold", 32'(bus.rd_addr_o), 32'd8);

    // Back-pressure pattern on buffer 0
    clear_logs();
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    run_idle(1, 150, "B");
    chk("B_beats", 32'(beats), 32'd8);
    chk_block("B", 0, 8, 1'b0);
    chk("B_outstanding_le2", 32'(maxout <= 2), 32'd1);
    chk("B_stable", 32'(stall_err), 32'd0);
    chk("B_blkcnt", 32'(block_cnt), 32'd2);

    // Overrun pulse (with simultaneous clear) around beat 4
    clear_logs();
    cyc(1'b1, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 40; i++) begin
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
      if (beats >= 4) break;
    end
    cyc(1'b1, 1'b1, 1'b0, 1'b1);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    chk("C_overrun_set", 32'(overrun), 32'd1);
    chk("C_blkcnt_now", 32'(block_cnt), 32'd2);
    run_idle(0, 80, "C");
`ifndef RDCTRL_RESTART_EN
    chk("C_beats", 32'(beats), 32'd8);
    chk_block("C", 0, 8, 1'b1);
    chk("C_rd_sel", 32'(bus.rd_buf_sel_o), 32'd1);
`else
    n = bdata.size();
    chk("C_old_beats_ge4", 32'(n >= 12), 32'd1);
    if (n >= 12) begin
      for (int k = 0; k < n - 8; k++)
        chk($sformatf("C_old_d%0d", k), 32'(bdata[k]), {8'd0, 15'd0, 1'b1, 8'(k)});
      chk_block("C_new", n - 8, 8, 1'b0);
    end
    chk("C_rd_sel", 32'(bus.rd_buf_sel_o), 32'd0);
`endif
    chk("C_blkcnt", 32'(block_cnt), 32'd3);
    chk("C_overrun_held", 32'(overrun), 32'd1);
    cyc(1'b1, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    chk("C_overrun_clr", 32'(overrun), 32'd0);

    // New pulse coincident with the last handshake
    clear_logs();
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 60; i++) begin
      r = (beats < 7);
      cyc(r, 1'b0, 1'b0, 1'b0);
      if ((bus.m_valid_o && bus.m_last_o && !r) || beats >= 8) break;
    end
    chk("E_last_at_head", 32'(bus.m_valid_o && bus.m_last_o), 32'd1);
    cyc(1'b1, 1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    chk("E_overrun", 32'(overrun), 32'd0);
    chk("E_busy", 32'(busy), 32'd1);
    chk("E_rd_sel", 32'(bus.rd_buf_sel_o), 32'd1);
    chk("E_blkcnt_mid", 32'(block_cnt), 32'd4);
    run_idle(0, 100, "E");
    chk("E_beats", 32'(beats), 32'd16);
    chk_block("E1", 0, 8, 1'b0);
    chk_block("E2", 8, 8, 1'b1);
    chk("E_blkcnt", 32'(block_cnt), 32'd5);
    chk("E_overrun_end", 32'(overrun), 32'd0);

    // Asynchronous reset during beat 5, then a clean block
    clear_logs();
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) begin
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
      if (beats >= 5) break;
    end
    chk("F_mid_block", 32'(busy), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk_reset("F_rst");
    @(negedge clk);
    rst_n = 1'b1;
    clear_logs();
    cyc(1'b1, 1'b1, 1'b1, 1'b0);
    run_idle(0, 60, "F");
    chk("F_beats", 32'(beats), 32'd8);
    chk_block("F", 0, 8, 1'b1);
    chk("F_blkcnt", 32'(block_cnt), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, required finish before 500000");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/pingpong_read_ctrl.md
PINGPONG_READ_CTRL -- requirements
Module: pingpong_read_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 24, sample width in bits.
REQ-002 SHALL have parameter DEPTH, default 256, samples per buffer (2..256).
REQ-003 SHALL have parameter AW, default 8, read address width; DEPTH <= 2**AW.
REQ-004 SHALL have port clk_i  input  1  single clock, all logic on rising edge.
REQ-005 SHALL have port rst_ni  input  1  asynchronous active-low reset.
REQ-006 SHALL have port buffer_ready_i  input  1  one-cycle pulse: a buffer has been filled.
REQ-007 SHALL have port buf_sel_i  input  1  index of the filled buffer; valid with buffer_ready_i.
REQ-008 SHALL have port rd_en_o  output  1  read strobe to the ping-pong RAM.
REQ-009 SHALL have port rd_addr_o  output  AW  read address.
REQ-010 SHALL have port rd_buf_sel_o  output  1  buffer being read.
REQ-011 SHALL have port rd_data_i  input  WIDTH  RAM read data, valid one cycle after rd_en_o.
REQ-012 SHALL have port m_data_o  output  WIDTH  stream data to the FFT.
REQ-013 SHALL have port m_valid_o  output  1  stream valid.
REQ-014 SHALL have port m_ready_i  input  1  stream ready from the FFT.
REQ-015 SHALL have port m_last_o  output  1  marks sample DEPTH-1 of a block.
REQ-016 SHALL have port busy_o  output  1  high whenever the state is not IDLE.
REQ-017 SHALL have port overrun_o  output  1  sticky overrun flag.
REQ-018 SHALL have port overrun_clr_i  input  1  one-cycle clear of overrun_o.
REQ-019 SHALL have port block_cnt_o  output  16  completed-block counter.

Function
REQ-020 SHALL implement states IDLE, RUN and DRAIN.
REQ-021 In IDLE, buffer_ready_i SHALL latch buf_sel_i into rd_buf_sel_o, clear the address to 0 and enter RUN.
REQ-022 In RUN, rd_en_o SHALL be asserted only when (output FIFO occupancy + reads in flight) < 2; the FIFO is 2 entries deep.
REQ-023 Each rd_en_o SHALL increment rd_addr_o by 1 on the next cycle; the issue at address DEPTH-1 SHALL move the FSM to DRAIN.
REQ-024 rd_data_i SHALL be written into the FIFO on the cycle after rd_en_o, so the first m_valid_o rises 3 cycles after buffer_ready_i when m_ready_i=1.
REQ-025 m_data_o, m_valid_o and m_last_o SHALL be driven from the FIFO head and SHALL remain stable while m_valid_o=1 and m_ready_i=0.
REQ-026 A beat SHALL transfer when m_valid_o and m_ready_i are both high; exactly DEPTH beats SHALL be produced per block, addresses 0..DEPTH-1 in order.
REQ-027 In DRAIN, acceptance of the m_last_o beat SHALL return the FSM to IDLE and increment block_cnt_o, which wraps from 0xFFFF to 0.
REQ-028 A buffer_ready_i in the same cycle as the m_last_o transfer SHALL be treated as an IDLE start, without overrun.
REQ-029 A buffer_ready_i in RUN or DRAIN, other than the case in REQ-028, SHALL set overrun_o; set SHALL have priority over overrun_clr_i.
REQ-030 rd_addr_o and rd_buf_sel_o SHALL hold their values when rd_en_o=0.

Reset
REQ-031 Reset SHALL force state IDLE, rd_en_o=0, rd_addr_o=0, rd_buf_sel_o=0, FIFO empty, m_valid_o=0, m_last_o=0, m_data_o=0, busy_o=0, overrun_o=0, block_cnt_o=0.
REQ-032 Reset asserted mid-block SHALL discard in-flight reads and SHALL NOT increment block_cnt_o.

Configuration
REQ-033 Macro RDCTRL_RESTART_EN defined: an overrun pulse SHALL flush the FIFO and in-flight reads, latch the new buf_sel_i, reset the address to 0 and enter RUN; the aborted block SHALL NOT count.
REQ-034 Macro RDCTRL_RESTART_EN undefined: an overrun pulse SHALL be ignored apart from setting overrun_o, and the current block SHALL complete normally.

Verification (DEPTH=8)
REQ-035 Pulse with buf_sel_i=1 and m_ready_i=1 -> rd_buf_sel_o=1, rd_addr_o 0..7, 8 beats, m_last_o on beat 8, block_cnt_o=1, busy_o falls after the last beat.
REQ-036 m_ready_i toggling 1,0,0,1,... -> no beat lost or duplicated; data matches RAM contents 0..7 in order; at most 2 reads outstanding.
REQ-037 Second pulse at beat 4: without the macro -> overrun_o=1 and 8 beats of the old buffer; with the macro -> overrun_o=1, a new block from address 0, block_cnt_o unchanged.
REQ-038 Pulse coincident with the m_last_o handshake -> overrun_o stays 0 and the next block starts on the other buffer.
REQ-039 rst_ni low during beat 5 -> all outputs at reset values immediately; after release, a new pulse gives a clean 8-beat block.
REQ-040 overrun_clr_i and an overrun pulse in the same cycle -> overrun_o=1.
